// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding, line levels and width helpers for
// the serial_tx_piso transmitter and its baud generator.
package serial_tx_pkg;

  // Frame states. PARITY is only reachable when SERIAL_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Line levels for the framed bit stream.
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Counter width able to hold 0..count-1, never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/serial_tx_piso_if.sv
// serial_tx_piso_if: word handshake plus serial line and status signals
// between a producer (master) and the transmitter (slave).
interface serial_tx_piso_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_serial;
  logic             tx_busy;
  logic             tx_done;

  // Producer side: offers words, observes the transmitter.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );

  // Transmitter side: accepts words, drives the line and status.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_serial,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled
// and flags the last cycle of each bit period with bit_tick, so the owner
// advances exactly at the wrap edge.
module serial_baud_gen
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  // Period counter; clear restarts the period so the start bit gets full length.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      if (cnt_reg == LAST) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bit_tick = enable && (cnt_reg == LAST);

endmodule

// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in/serial-out framed transmitter.
// Frame: start 0, WIDTH data bits LSB first, optional even parity, stop 1,
// each bit held CLKS_PER_BIT clocks. Optional parity bit is enabled by
// defining SERIAL_TX_PARITY_EN.
module serial_tx_piso
  import serial_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  serial_tx_piso_if.slave tx
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state_reg,   state_next;
  logic [WIDTH-1:0] shift_reg,   shift_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic             serial_reg,  serial_next;
  logic             done_reg,    done_next;
  logic             busy;
  logic             xfer;
  logic             bit_tick;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_reg;
`endif

  // Status comes only from the registered state, never from tx_valid.
  assign busy = (state_reg != IDLE);
  assign xfer = tx.tx_valid && !busy;

  serial_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (xfer),
    .enable  (busy),
    .bit_tick(bit_tick)
  );

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the accepted word, captured at the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else if (xfer) begin
      parity_reg <= ^tx.tx_data;
    end
  end
`endif

  // State, datapath and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      serial_reg  <= IDLE_LEVEL;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      serial_reg  <= serial_next;
      done_reg    <= done_next;
    end
  end

  // Next-state and next-line-level logic; the line level is computed for the
  // state being entered so tx_serial changes on the same edge as the state.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    serial_next  = serial_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        serial_next = IDLE_LEVEL;
        if (xfer) begin
          state_next   = START;
          shift_next   = tx.tx_data;
          bit_cnt_next = '0;
          serial_next  = START_LEVEL;
        end
      end

      START: begin
        if (bit_tick) begin
          state_next  = DATA;
          serial_next = shift_reg[0];
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_next  = PARITY;
            serial_next = parity_reg;
`else
            state_next  = STOP;
            serial_next = STOP_LEVEL;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = shift_reg >> 1;
            serial_next  = shift_next[0];
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_next  = STOP;
          serial_next = STOP_LEVEL;
        end
      end
`endif

      STOP: begin
        if (bit_tick) begin
          state_next  = IDLE;
          serial_next = IDLE_LEVEL;
          done_next   = 1'b1;
        end
      end

      default: begin
        state_next  = IDLE;
        serial_next = IDLE_LEVEL;
      end
    endcase
  end

  assign tx.tx_busy   = busy;
  assign tx.tx_ready  = ~busy;
  assign tx.tx_serial = serial_reg;
  assign tx.tx_done   = done_reg;

endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
- Parallel-in/serial-out transmitter. It is the sending end of the serial link whose receive side is a chain of D flip-flops (serial-in/parallel-out capture).
- Accepts a WIDTH-bit word via a valid/ready handshake. Serialises it as a framed, LSB-first bit stream: start bit 0, data bits, stop bit 1, each held CLKS_PER_BIT clocks.
- Sits between lab-board datapath logic and the single-wire serial output pin.

Parameters:
- WIDTH, 8, data bits per frame; range 1..32.
- CLKS_PER_BIT, 4, clk cycles each serial bit is held; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  WIDTH  word to send; sampled only on handshake.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block is idle and will accept a word this cycle.
- tx_serial  output  1  registered serial line; idles high.
- tx_busy  output  1  a frame is in progress (not IDLE).
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register, bit counter and baud counter all clear.
- States: IDLE -> START -> DATA -> STOP -> IDLE (PARITY is inserted between DATA and STOP when the optional feature is enabled).
- Handshake:
  - Transfer occurs at an edge where tx_valid=1 and tx_ready=1.
  - tx_ready is 1 only in IDLE.
  - tx_data is latched into the shift register on transfer. Later changes to tx_data are ignored.
  - tx_valid while busy is ignored; nothing is queued.
- Latency: tx_serial goes 0 (start bit) from the edge that performs the transfer.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1.
  - Each bit is held exactly CLKS_PER_BIT cycles. The state or bit advances when the counter wraps.
  - Counter width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - CLKS_PER_BIT=1 gives one bit per cycle.
- DATA:
  - tx_serial = shift_reg[0]; the register shifts right at each bit boundary.
  - The bit counter runs 0..WIDTH-1 and DATA exits after bit WIDTH-1.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles. At its last edge: state goes to IDLE, tx_done=1 for one cycle, tx_ready=1.
- Frame length:
  - (WIDTH+2)*CLKS_PER_BIT cycles from transfer edge to IDLE.
  - Back-to-back frames have at least 1 extra idle-high cycle, because the transfer happens in IDLE.
- Simultaneous events: reset has priority over the handshake and all counters.
- Reset mid-frame: the frame is aborted, tx_serial=1 from that edge, and no tx_done pulse.
- tx_busy = (state != IDLE); tx_ready = ~tx_busy. Both are registered-state derived, with no combinational path from tx_valid.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and sends the even-parity bit (XOR of the latched word) for CLKS_PER_BIT cycles.
  - Frame becomes (WIDTH+3)*CLKS_PER_BIT cycles.
  - Parity is computed at transfer and stored.
- Undefined: no PARITY state, no parity register; frame length as in Behaviour.

Decomposition:
- Package serial_tx_pkg holds:
  - state typedef (IDLE, START, DATA, PARITY, STOP);
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1;
  - a clog2 helper constant function.
- One sub-module: serial_baud_gen.
  - Parameterised counter with sync clear.
  - Outputs a one-cycle bit_tick on the wrap.
  - Cleared when the transfer occurs and on reset.

Test Plan:
- WIDTH=8, CLKS_PER_BIT=4, send 0xA5 -> tx_serial = 0, 1,0,1,0,0,1,0,1, 1, each for 4 cycles. tx_done pulses once, 40 cycles after the transfer edge. tx_ready returns to 1 in the same cycle.
- Hold tx_valid=1 with 0x3C then 0xC3 -> two frames, separated by at least 1 idle-high cycle. The second word is accepted only when tx_ready=1. Decoded bits match both words.
- Change tx_data from 0x0F to 0xF0 during the DATA state of a 0x0F frame -> the serialised bits remain 0x0F.
- Assert reset for 1 cycle during DATA bit 3 -> tx_serial=1 from that edge. No tx_done. tx_ready=1. A new 0x55 frame then sends correctly.
- CLKS_PER_BIT=1, send 0xFF -> 10-cycle frame: 0, eight 1s, then stop 1.
- With SERIAL_TX_PARITY_EN, send 0xA5 -> parity bit 0 before stop, 44-cycle frame. Send 0x07 -> parity bit 1.
